// File: rtl/pmp_check_arbiter.sv
// Arbitrates fetch and data PMP check requests onto one shared combinational
// PMP checker and returns a per-requester fault result.
module pmp_check_arbiter #(
  parameter int PA_BITS = 56
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               IReqValid,
  input  logic [PA_BITS-1:0] IReqAdr,
  input  logic [1:0]         IReqPriv,
  output logic               IReqReady,
  input  logic               IFlush,
  output logic               IRespValid,
  output logic               IRespFault,
  input  logic               DReqValid,
  input  logic [PA_BITS-1:0] DReqAdr,
  input  logic [1:0]         DReqPriv,
  input  logic               DReqWrite,
  output logic               DReqReady,
  output logic               DRespValid,
  output logic               DRespFault,
  input  logic               PMPBusy,
  output logic [PA_BITS-1:0] ChkAdr,
  output logic [1:0]         ChkPriv,
  output logic               ChkExecute,
  output logic               ChkRead,
  output logic               ChkWrite,
  input  logic               ChkInstrFault,
  input  logic               ChkLoadFault,
  input  logic               ChkStoreFault,
  output logic [1:0]         DbgState
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CHK  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  localparam logic [1:0] ACC_EXEC  = 2'd0;
  localparam logic [1:0] ACC_READ  = 2'd1;
  localparam logic [1:0] ACC_WRITE = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Handshake: a request transfers in a cycle where ReqValid and ReqReady are
  // both high; the requester holds valid and fields stable until then.
  logic [1:0]         r_state;
  logic [PA_BITS-1:0] r_adr;
  logic [1:0]         r_priv;
  logic [1:0]         r_acc;
  logic               r_owner;
  logic               r_last_grant;
  logic               r_fault;

  logic       w_accept_slot;
  logic       w_i_req;
  logic       w_grant_i;
  logic       w_grant_d;
  logic       w_handshake;
  logic       w_i_flush_hit;
  logic       w_fault_sel;
  logic       w_in_chk;
  logic       w_in_rsp;
  logic [1:0] w_state_nxt;

  // Reset gates Ready so nothing is accepted while reset_n is held low.
  assign w_accept_slot = reset_n && !PMPBusy &&
                         ((r_state == ST_IDLE) || (r_state == ST_RSP));
  assign w_i_req       = IReqValid && !IFlush;
  assign w_grant_i     = w_accept_slot && w_i_req &&
                         (!DReqValid || (r_last_grant == OWN_D));
  assign w_grant_d     = w_accept_slot && DReqValid &&
                         (!w_i_req || (r_last_grant == OWN_I));
  assign w_handshake   = w_grant_i || w_grant_d;
  assign w_i_flush_hit = IFlush && (r_owner == OWN_I);
  assign w_in_chk      = (r_state == ST_CHK);
  assign w_in_rsp      = (r_state == ST_RSP);

  always_comb begin
    w_fault_sel = 1'b0;
    case (r_acc)
      ACC_EXEC:  w_fault_sel = ChkInstrFault;
      ACC_READ:  w_fault_sel = ChkLoadFault;
      ACC_WRITE: w_fault_sel = ChkStoreFault;
      default:   w_fault_sel = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_handshake) w_state_nxt = ST_CHK;
      ST_CHK: begin
        if (w_i_flush_hit)  w_state_nxt = ST_IDLE;
        else if (!PMPBusy)  w_state_nxt = ST_RSP;
      end
      ST_RSP:  w_state_nxt = w_handshake ? ST_CHK : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_adr        <= '0;
      r_priv       <= 2'd0;
      r_acc        <= ACC_EXEC;
      r_owner      <= OWN_I;
      r_last_grant <= OWN_D;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_handshake) begin
        r_adr        <= w_grant_d ? DReqAdr : IReqAdr;
        r_priv       <= w_grant_d ? DReqPriv : IReqPriv;
        r_acc        <= w_grant_d ? (DReqWrite ? ACC_WRITE : ACC_READ) : ACC_EXEC;
        r_owner      <= w_grant_d ? OWN_D : OWN_I;
        r_last_grant <= w_grant_d ? OWN_D : OWN_I;
      end
      // Result is only sampled once the PMP CSRs are stable.
      if (w_in_chk && !PMPBusy && !w_i_flush_hit) r_fault <= w_fault_sel;
    end
  end

  assign IReqReady  = w_grant_i;
  assign DReqReady  = w_grant_d;
  assign ChkAdr     = r_adr;
  assign ChkPriv    = r_priv;
  assign ChkExecute = w_in_chk && (r_acc == ACC_EXEC);
  assign ChkRead    = w_in_chk && (r_acc == ACC_READ);
  assign ChkWrite   = w_in_chk && (r_acc == ACC_WRITE);
  assign IRespValid = w_in_rsp && (r_owner == OWN_I) && !IFlush;
  assign DRespValid = w_in_rsp && (r_owner == OWN_D);
  assign IRespFault = IRespValid && r_fault;
  assign DRespFault = DRespValid && r_fault;
  assign DbgState   = r_state;

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Directed bench for pmp_check_arbiter: stimulus changes 1 ns after the rising
// edge, outputs are checked on the falling edge against hand-computed values.
module tb_pmp_check_arbiter;

  localparam int PA_BITS = 56;

  logic               clk;
  logic               reset_n;
  logic               IReqValid, IReqReady, IFlush, IRespValid, IRespFault;
  logic [PA_BITS-1:0] IReqAdr;
  logic [1:0]         IReqPriv;
  logic               DReqValid, DReqWrite, DReqReady, DRespValid, DRespFault;
  logic [PA_BITS-1:0] DReqAdr;
  logic [1:0]         DReqPriv;
  logic               PMPBusy;
  logic [PA_BITS-1:0] ChkAdr;
  logic [1:0]         ChkPriv;
  logic               ChkExecute, ChkRead, ChkWrite;
  logic               ChkInstrFault, ChkLoadFault, ChkStoreFault;
  logic [1:0]         DbgState;

  int n_checks = 0;
  int n_errors = 0;
  logic [0:0] exp_q[$];

  pmp_check_arbiter #(.PA_BITS(PA_BITS)) dut (
    .clk(clk), .reset_n(reset_n),
    .IReqValid(IReqValid), .IReqAdr(IReqAdr), .IReqPriv(IReqPriv),
    .IReqReady(IReqReady), .IFlush(IFlush),
    .IRespValid(IRespValid), .IRespFault(IRespFault),
    .DReqValid(DReqValid), .DReqAdr(DReqAdr), .DReqPriv(DReqPriv),
    .DReqWrite(DReqWrite), .DReqReady(DReqReady),
    .DRespValid(DRespValid), .DRespFault(DRespFault),
    .PMPBusy(PMPBusy), .ChkAdr(ChkAdr), .ChkPriv(ChkPriv),
    .ChkExecute(ChkExecute), .ChkRead(ChkRead), .ChkWrite(ChkWrite),
    .ChkInstrFault(ChkInstrFault), .ChkLoadFault(ChkLoadFault),
    .ChkStoreFault(ChkStoreFault), .DbgState(DbgState)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    IReqValid = 0; IReqAdr = '0; IReqPriv = 0; IFlush = 0;
    DReqValid = 0; DReqAdr = '0; DReqPriv = 0; DReqWrite = 0;
    PMPBusy = 0; ChkInstrFault = 0; ChkLoadFault = 0; ChkStoreFault = 0;
  endtask

  // Expected per-cycle values for the held-tie alternation sequence.
  logic       tie_i_rdy [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
  logic       tie_d_rdy [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
  logic [1:0] tie_state [8] = '{0, 1, 2, 1, 2, 1, 2, 0};

  initial begin
    clear_inputs();
    reset_n = 1;
    #2 reset_n = 0;
    IReqValid = 1;
    sample();
    check("rst_iready", IReqReady, 0);
    check("rst_state", DbgState, 0);
    check("rst_chkadr", ChkAdr, 0);
    check("rst_chkpriv", ChkPriv, 0);
    check("rst_strobes", {ChkExecute, ChkRead, ChkWrite}, 0);
    check("rst_resp", {IRespValid, IRespFault, DRespValid, DRespFault}, 0);

    // Basic fetch: ready t, execute strobe t+1, response t+2
    next_cycle(); next_cycle();
    reset_n = 1; IReqValid = 1; IReqAdr = 56'h8000_0000; IReqPriv = 2'd3;
    sample();
    check("f_iready", IReqReady, 1);
    check("f_dready", DReqReady, 0);
    next_cycle(); IReqValid = 0;
    sample();
    check("f_state_chk", DbgState, 1);
    check("f_strobes", {ChkExecute, ChkRead, ChkWrite}, 3'b100);
    check("f_chkadr", ChkAdr, 64'h8000_0000);
    check("f_chkpriv", ChkPriv, 3);
    check("f_no_early_rsp", IRespValid, 0);
    next_cycle();
    sample();
    check("f_irsp", {IRespValid, IRespFault}, 2'b10);
    check("f_strobes_off", {ChkExecute, ChkRead, ChkWrite}, 0);
    check("f_chkadr_hold", ChkAdr, 64'h8000_0000);
    next_cycle();
    sample();
    check("f_idle", DbgState, 0);
    check("f_irsp_pulse", IRespValid, 0);

    // Tie from reset: I first, then strict alternation
    next_cycle(); reset_n = 0;
    sample();
    check("rst2_state", DbgState, 0);
    next_cycle(); reset_n = 1;
    IReqValid = 1; IReqAdr = 56'h100; DReqValid = 1; DReqAdr = 56'h200; DReqWrite = 0;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      if (i == 6) begin IReqValid = 0; DReqValid = 0; end
      sample();
      check($sformatf("tie_iready_%0d", i), IReqReady, tie_i_rdy[i]);
      check($sformatf("tie_dready_%0d", i), DReqReady, tie_d_rdy[i]);
      check($sformatf("tie_state_%0d", i), DbgState, tie_state[i]);
      if (IRespValid || DRespValid) begin
        if (exp_q.size() > 0) check($sformatf("tie_owner_%0d", i), DRespValid, exp_q.pop_front());
        else check("tie_resp_extra", exp_q.size(), 1);
      end
      if (i == 3) check("tie_chkadr_d", ChkAdr, 64'h200);
    end
    check("tie_resp_missing", exp_q.size(), 0);

    // Store with fault, back-to-back load without fault
    next_cycle();
    DReqValid = 1; DReqWrite = 1; DReqAdr = 56'h1000; DReqPriv = 2'd1;
    sample();
    check("st_dready", DReqReady, 1);
    next_cycle(); DReqValid = 0; ChkStoreFault = 1;
    sample();
    check("st_strobes", {ChkExecute, ChkRead, ChkWrite}, 3'b001);
    check("st_chkadr", ChkAdr, 64'h1000);
    check("st_chkpriv", ChkPriv, 1);
    next_cycle(); DReqValid = 1; DReqWrite = 0;
    sample();
    check("st_drsp", {DRespValid, DRespFault}, 2'b11);
    check("st_irsp", IRespValid, 0);
    check("ld_dready_rsp", DReqReady, 1);
    next_cycle(); DReqValid = 0;
    sample();
    check("ld_strobes", {ChkExecute, ChkRead, ChkWrite}, 3'b010);
    next_cycle();
    sample();
    check("ld_drsp", {DRespValid, DRespFault}, 2'b10);
    next_cycle(); ChkStoreFault = 0;
    sample();
    check("ld_done", {DRespValid, DRespFault, DbgState}, 0);

    // PMPBusy: no ready while busy, CHK replayed, result sampled after busy drops
    next_cycle(); PMPBusy = 1; IReqValid = 1; IReqAdr = 56'h2000;
    sample();
    check("busy_idle_iready", IReqReady, 0);
    next_cycle(); PMPBusy = 0;
    sample();
    check("busy_iready", IReqReady, 1);
    next_cycle(); IReqValid = 0; PMPBusy = 1; DReqValid = 1; DReqWrite = 0; DReqAdr = 56'h2400;
    sample();
    check("busy_chk0", {ChkExecute, DReqReady}, 2'b10);
    for (int k = 1; k < 3; k++) begin
      next_cycle();
      sample();
      check($sformatf("busy_chk%0d", k), {ChkExecute, DReqReady, IRespValid, DbgState}, 5'b10001);
    end
    next_cycle(); PMPBusy = 0; ChkInstrFault = 1;
    sample();
    check("busy_release", {ChkExecute, IRespValid, DReqReady}, 3'b100);
    next_cycle(); ChkInstrFault = 0;
    sample();
    check("busy_irsp", {IRespValid, IRespFault}, 2'b11);
    check("busy_dready", DReqReady, 1);
    next_cycle(); DReqValid = 0;
    sample();
    check("busy_d_strobe", ChkRead, 1);
    next_cycle();
    sample();
    check("busy_drsp", {DRespValid, DRespFault}, 2'b10);

    // IFlush: blocks I ready, never touches D, aborts I in CHK, hides I in RSP
    next_cycle();
    IReqValid = 1; IFlush = 1; DReqValid = 1; DReqWrite = 0; DReqAdr = 56'h3000;
    sample();
    check("fl_iready", IReqReady, 0);
    check("fl_dready", DReqReady, 1);
    next_cycle(); IReqValid = 0; DReqValid = 0; ChkLoadFault = 1;
    sample();
    check("fl_d_chk", {ChkRead, DbgState}, 3'b101);
    next_cycle();
    sample();
    check("fl_d_rsp", {DRespValid, DRespFault}, 2'b11);
    next_cycle(); IFlush = 0; ChkLoadFault = 0;
    sample();
    check("fl_d_idle", DbgState, 0);
    IReqValid = 1; IReqAdr = 56'h4000;
    #1;
    check("fl_i_ready", IReqReady, 1);
    next_cycle(); IReqValid = 0; IFlush = 1; ChkInstrFault = 1;
    sample();
    check("fl_i_chk", {DbgState, IRespValid}, 3'b010);
    next_cycle(); IFlush = 0; ChkInstrFault = 0;
    sample();
    check("fl_i_abort", {DbgState, IRespValid}, 3'b000);
    next_cycle(); IReqValid = 1;
    sample();
    check("fl_rsp_ready", IReqReady, 1);
    next_cycle(); IReqValid = 0;
    sample();
    check("fl_rsp_chk", ChkExecute, 1);
    next_cycle(); IFlush = 1;
    sample();
    check("fl_rsp_hidden", {IRespValid, IRespFault}, 0);
    next_cycle(); IFlush = 0;
    sample();
    check("fl_rsp_idle", DbgState, 0);

    // Reset in CHK: outputs drop at once, no response afterwards
    next_cycle(); IReqValid = 1; IReqAdr = 56'h5000;
    sample();
    check("rc_ready", IReqReady, 1);
    next_cycle(); IReqValid = 0;
    sample();
    check("rc_chk", ChkExecute, 1);
    #1 reset_n = 0;
    #1;
    check("rc_strobes", {ChkExecute, ChkRead, ChkWrite}, 0);
    check("rc_state", DbgState, 0);
    check("rc_chkadr", ChkAdr, 0);
    check("rc_resp", {IRespValid, DRespValid}, 0);
    next_cycle(); reset_n = 1;
    sample();
    check("rc_after0", {IRespValid, DbgState}, 0);
    next_cycle();
    sample();
    check("rc_after1", {IRespValid, DbgState}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pmp_check_arbiter.md
PMP_CHECK_ARBITER -- requirements
Module: pmp_check_arbiter

Interface
REQ-001 Parameter: PA_BITS, default 56, physical address width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 IReqValid  in  1  fetch-side check request.
REQ-005 IReqAdr  in  PA_BITS  fetch physical address.
REQ-006 IReqPriv  in  2  fetch privilege mode.
REQ-007 IReqReady  out  1  fetch request accepted this cycle.
REQ-008 IFlush  in  1  cancel fetch-side transaction.
REQ-009 IRespValid  out  1  fetch result valid, single-cycle pulse.
REQ-010 IRespFault  out  1  fetch access fault result.
REQ-011 DReqValid  in  1  data-side check request.
REQ-012 DReqAdr  in  PA_BITS  data physical address.
REQ-013 DReqPriv  in  2  data privilege mode.
REQ-014 DReqWrite  in  1  1 = store/AMO, 0 = load.
REQ-015 DReqReady  out  1  data request accepted this cycle.
REQ-016 DRespValid  out  1  data result valid, single-cycle pulse.
REQ-017 DRespFault  out  1  data access fault result.
REQ-018 PMPBusy  in  1  pmpcfg/pmpaddr CSR write in progress.
REQ-019 ChkAdr  out  PA_BITS; ChkPriv  out  2; ChkExecute, ChkRead, ChkWrite  out  1 each: drive shared PMP checker.
REQ-020 ChkInstrFault, ChkLoadFault, ChkStoreFault  in  1 each: combinational checker results, same cycle.

Function
REQ-021 FSM states: IDLE, CHK, RSP.
REQ-022 Handshake: ReqValid & ReqReady in the same cycle; requester holds valid and fields stable until ready; no input buffering.
REQ-023 Ready asserted only in IDLE or RSP, only with PMPBusy low, to at most one requester per cycle.
REQ-024 Arbitration: single valid requester is granted; both valid means grant opposite of LastGrant register; LastGrant updates on every handshake.
REQ-025 IReqReady forced low in any cycle IFlush is high.
REQ-026 On handshake: register address, priv, access type (I = execute, D = DReqWrite ? write : read), owner ID; next state CHK.
REQ-027 CHK: ChkAdr/ChkPriv from registers; exactly one Chk strobe high matching access type.
REQ-028 CHK with PMPBusy high: stay in CHK, strobes stay high (replay) until PMPBusy low; no result sampled.
REQ-029 CHK with PMPBusy low: capture fault (execute -> ChkInstrFault, read -> ChkLoadFault, write -> ChkStoreFault); next state RSP.
REQ-030 RSP: owner RespValid high exactly one cycle with captured fault; other RespValid low; next state CHK on new handshake, else IDLE.
REQ-031 Latency: handshake cycle t, CHK cycle t+1, RespValid cycle t+2 when PMPBusy low; back-to-back sustains one result per 2 cycles.
REQ-032 IFlush high while I-owned transaction in CHK: abort to IDLE, no IRespValid; in RSP: IRespValid suppressed.
REQ-033 IFlush never affects a D-owned transaction.
REQ-034 Outside CHK: all Chk strobes low; ChkAdr/ChkPriv hold last value.
REQ-035 RespFault outputs are 0 whenever the corresponding RespValid is low.

Reset
REQ-036 reset_n low: state IDLE, Ready/RespValid/RespFault/Chk strobes 0, ChkAdr 0, ChkPriv 0, LastGrant = D (fetch wins first tie).
REQ-037 Reset mid-transaction: transaction discarded, no response after reset release.

Verification
REQ-038 IReqValid, IReqAdr=0x8000_0000, ChkInstrFault=0 -> IReqReady cycle 0, ChkExecute cycle 1, IRespValid=1 IRespFault=0 cycle 2.
REQ-039 IReqValid and DReqValid together from reset, held -> I granted first, D next (RSP cycle), then I; strict alternation.
REQ-040 D store, ChkStoreFault=1 -> ChkWrite in CHK, DRespValid=1 DRespFault=1; D load same address, ChkLoadFault=0 -> DRespFault=0.
REQ-041 PMPBusy high 3 cycles during CHK -> strobes held 3 extra cycles, response 3 cycles late, no Ready while busy.
REQ-042 IFlush in CHK of I transaction -> no IRespValid, FSM IDLE next; IFlush during D transaction -> DRespValid unaffected.
REQ-043 reset_n low in CHK -> all outputs 0 immediately; no response after release.
